// File: rtl/shared_mem_row_arbiter.sv
// Round-robin N-core arbiter and registered port mux for one row-shared URAM port.
// Define ARB_TIMEOUT_EN to force-revoke unlocked grants after MAX_HOLD_CYCLES cycles.
module shared_mem_row_arbiter #(
  parameter int NUM_CORES       = 4,
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_HOLD_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             i_core_req,
  input  logic [NUM_CORES-1:0]             i_core_locked,
  output logic [NUM_CORES-1:0]             o_core_grant,
  input  logic [NUM_CORES-1:0]             i_core_uram_en,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  i_core_uram_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  i_core_uram_wr_data,
  input  logic [NUM_CORES-1:0]             i_core_uram_wr_en,
  output logic                             o_uram_en,
  output logic [ADDR_WIDTH-1:0]            o_uram_addr,
  output logic [DATA_WIDTH-1:0]            o_uram_wr_data,
  output logic                             o_uram_wr_en,
  input  logic                             i_drain_busy,
  output logic                             o_uram_emptied
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic                   emptied_q, emptied_d;
  logic                   uram_en_q, uram_en_d;
  logic [ADDR_WIDTH-1:0]  uram_addr_q, uram_addr_d;
  logic [DATA_WIDTH-1:0]  uram_wr_data_q, uram_wr_data_d;
  logic                   uram_wr_en_q, uram_wr_en_d;

  logic [NUM_CORES-1:0]   cand;
  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       ptr_after_g;
  logic                   g_active;
  logic                   hold_expired;

  assign cand        = i_core_req | i_core_locked;
  assign g_active    = cand[gidx_q];
  assign ptr_after_g = (gidx_q == IDX_W'(NUM_CORES - 1)) ? '0 : gidx_q + IDX_W'(1);

  // First candidate at or after ptr, wrapping around.
  always_comb begin
    int j;
    arb_found = 1'b0;
    arb_idx   = '0;
    j         = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      j = (int'(ptr_q) + i) % NUM_CORES;
      if (!arb_found && cand[j]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(j);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD_CYCLES + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              g_locked;

  assign g_locked     = i_core_locked[gidx_q];
  assign hold_expired = !g_locked && (hold_q == HOLD_W'(MAX_HOLD_CYCLES - 1));

  always_comb begin
    hold_d = hold_q + HOLD_W'(1);
    if (state_q != S_GRANT || g_locked) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Constant false; the grant is only released by req and locked dropping.
  assign hold_expired = (MAX_HOLD_CYCLES < 0);
`endif

  // The release bubble also arbitrates, so a handover costs exactly one idle grant cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        grant_d = '0;
        state_d = S_IDLE;
        if (!i_drain_busy && arb_found) begin
          state_d          = S_GRANT;
          gidx_d           = arb_idx;
          grant_d[arb_idx] = 1'b1;
        end
      end
      S_GRANT: begin
        if (!g_active || hold_expired) begin
          state_d = S_RELEASE;
          grant_d = '0;
          ptr_d   = ptr_after_g;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Grant is one-hot or zero, so an AND-OR mux suffices and yields zero when idle.
  always_comb begin
    uram_en_d      = 1'b0;
    uram_addr_d    = '0;
    uram_wr_data_d = '0;
    uram_wr_en_d   = 1'b0;
    emptied_d      = !i_drain_busy && (state_q == S_IDLE);
    for (int k = 0; k < NUM_CORES; k++) begin
      if (grant_q[k]) begin
        uram_en_d      = uram_en_d | i_core_uram_en[k];
        uram_addr_d    = uram_addr_d | i_core_uram_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        uram_wr_data_d = uram_wr_data_d | i_core_uram_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        uram_wr_en_d   = uram_wr_en_d | i_core_uram_wr_en[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      gidx_q         <= '0;
      grant_q        <= '0;
      emptied_q      <= 1'b0;
      uram_en_q      <= 1'b0;
      uram_addr_q    <= '0;
      uram_wr_data_q <= '0;
      uram_wr_en_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gidx_q         <= gidx_d;
      grant_q        <= grant_d;
      emptied_q      <= emptied_d;
      uram_en_q      <= uram_en_d;
      uram_addr_q    <= uram_addr_d;
      uram_wr_data_q <= uram_wr_data_d;
      uram_wr_en_q   <= uram_wr_en_d;
    end
  end

  assign o_core_grant   = grant_q;
  assign o_uram_emptied = emptied_q;
  assign o_uram_en      = uram_en_q;
  assign o_uram_addr    = uram_addr_q;
  assign o_uram_wr_data = uram_wr_data_q;
  assign o_uram_wr_en   = uram_wr_en_q;

endmodule
